// File: rtl/des_key_schedule_ctrl.sv
// DES subkey sequencer: PC-1 load, per-round C/D rotation, PC-2, valid/ready stream of K1..K16 or K16..K1.
// Optional odd-parity key check enabled by defining DES_KS_PARITY_CHECK_EN.
module des_key_schedule_ctrl #(
  parameter logic [15:0] SHIFT_SCHED = 16'h8103
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key_in,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic        decrypt,
  input  logic        abort,
  output logic [47:0] round_key,
  output logic [3:0]  round_idx,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic        rk_last,
  output logic        sched_done,
  output logic        parity_err
);

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t      state;
  logic [27:0] c, d;
  logic        mode;
  logic        key_par_ok;
  logic [3:0]  sched_bit;
  logic [55:0] pc1_key;

  // Table entries use DES numbering: bit 1 is the MSB of the source vector.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    logic [5:0]  src, dst;
    r = '0;
    for (int unsigned j = 0; j < 56; j++) begin
      src    = 6'(64 - PC1_TBL[j]);
      dst    = 6'(55 - j);
      r[dst] = k[src];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    logic [5:0]  src, dst;
    r = '0;
    for (int unsigned j = 0; j < 48; j++) begin
      src    = 6'(56 - PC2_TBL[j]);
      dst    = 6'(47 - j);
      r[dst] = cd[src];
    end
    return r;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic one);
    return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic one);
    return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  assign pc1_key   = pc1(key_in);
  assign round_key = pc2({c, d});

  // Schedule bit for the round produced by the next rotation.
  always_comb begin
    sched_bit = mode ? (4'd15 - round_idx) : (round_idx + 4'd1);
  end

`ifdef DES_KS_PARITY_CHECK_EN
  assign key_par_ok = (^key_in[63:56]) & (^key_in[55:48]) & (^key_in[47:40]) & (^key_in[39:32])
                    & (^key_in[31:24]) & (^key_in[23:16]) & (^key_in[15:8])  & (^key_in[7:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= (state == IDLE) && key_valid && !key_par_ok;
  end
`else
  assign key_par_ok = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      c          <= '0;
      d          <= '0;
      mode       <= 1'b0;
      round_idx  <= '0;
      rk_valid   <= 1'b0;
      rk_last    <= 1'b0;
      sched_done <= 1'b0;
      key_ready  <= 1'b1;
    end else begin
      sched_done <= 1'b0;
      case (state)
        IDLE: begin
          if (key_valid && key_par_ok) begin
            state     <= RUN;
            mode      <= decrypt;
            round_idx <= '0;
            rk_valid  <= 1'b1;
            rk_last   <= 1'b0;
            key_ready <= 1'b0;
            if (decrypt) begin
              c <= pc1_key[55:28];
              d <= pc1_key[27:0];
            end else begin
              c <= rotl(pc1_key[55:28], SHIFT_SCHED[0]);
              d <= rotl(pc1_key[27:0],  SHIFT_SCHED[0]);
            end
          end
        end
        RUN: begin
          if (abort) begin
            state     <= IDLE;
            rk_valid  <= 1'b0;
            rk_last   <= 1'b0;
            round_idx <= '0;
            key_ready <= 1'b1;
          end else if (rk_ready) begin
            if (round_idx == 4'd15) begin
              state      <= IDLE;
              rk_valid   <= 1'b0;
              rk_last    <= 1'b0;
              round_idx  <= '0;
              key_ready  <= 1'b1;
              sched_done <= 1'b1;
            end else begin
              round_idx <= round_idx + 4'd1;
              rk_last   <= (round_idx == 4'd14);
              if (mode) begin
                c <= rotr(c, SHIFT_SCHED[sched_bit]);
                d <= rotr(d, SHIFT_SCHED[sched_bit]);
              end else begin
                c <= rotl(c, SHIFT_SCHED[sched_bit]);
                d <= rotl(d, SHIFT_SCHED[sched_bit]);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_key_schedule_ctrl.sv
// Directed bench for des_key_schedule_ctrl using the classic 133457799BBCDFF1 subkey vectors.
module tb_des_key_schedule_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] key_in = '0;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic        decrypt = 1'b0;
  logic        abort = 1'b0;
  logic [47:0] round_key;
  logic [3:0]  round_idx;
  logic        rk_valid;
  logic        rk_ready = 1'b1;
  logic        rk_last;
  logic        sched_done;
  logic        parity_err;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

  logic [47:0] kexp [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  des_key_schedule_ctrl #(.SHIFT_SCHED(16'h8103)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .decrypt(decrypt), .abort(abort), .round_key(round_key), .round_idx(round_idx),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_last(rk_last), .sched_done(sched_done),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_key(input int i, input logic dec);
    chk($sformatf("rk[%0d]", i), {16'h0, round_key}, {16'h0, dec ? kexp[15-i] : kexp[i]});
    chk($sformatf("idx[%0d]", i), {60'h0, round_idx}, 64'(i));
    chk($sformatf("last[%0d]", i), {63'h0, rk_last}, {63'h0, (i == 15)});
    chk($sformatf("valid[%0d]", i), {63'h0, rk_valid}, 64'd1);
    chk($sformatf("kready[%0d]", i), {63'h0, key_ready}, 64'd0);
  endtask

  task automatic send_key(input logic [63:0] k, input logic dec);
    key_in    = k;
    decrypt   = dec;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic expect_run(input logic dec);
    for (int i = 0; i < 16; i++) begin
      chk_key(i, dec);
      @(negedge clk);
    end
    chk("done_pulse", {63'h0, sched_done}, 64'd1);
    chk("done_valid", {63'h0, rk_valid}, 64'd0);
    chk("done_kready", {63'h0, key_ready}, 64'd1);
    @(negedge clk);
    chk("done_clear", {63'h0, sched_done}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_kready", {63'h0, key_ready}, 64'd1);
    chk("rst_valid", {63'h0, rk_valid}, 64'd0);
    chk("rst_idx", {60'h0, round_idx}, 64'd0);
    chk("rst_last", {63'h0, rk_last}, 64'd0);
    chk("rst_done", {63'h0, sched_done}, 64'd0);
    chk("rst_perr", {63'h0, parity_err}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: encrypt, streaming
    send_key(KEY, 1'b0);
    expect_run(1'b0);

    // Test 2: decrypt, reverse order
    send_key(KEY, 1'b1);
    expect_run(1'b1);

    // Test 3: backpressure at idx3, plus a key offered mid-run that must be ignored
    send_key(KEY, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk_key(i, 1'b0);
      if (i == 1) begin
        key_in    = '0;
        key_valid = 1'b1;
      end
      if (i == 2) key_valid = 1'b0;
      if (i == 3) begin
        rk_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk_key(3, 1'b0);
        end
        rk_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk("bp_done", {63'h0, sched_done}, 64'd1);
    @(negedge clk);

    // Test 4: abort with a handshake at idx7; then abort in IDLE alongside a new key
    send_key(KEY, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk_key(i, 1'b0);
      if (i == 7) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    chk("abort_valid", {63'h0, rk_valid}, 64'd0);
    chk("abort_kready", {63'h0, key_ready}, 64'd1);
    chk("abort_idx", {60'h0, round_idx}, 64'd0);
    chk("abort_done", {63'h0, sched_done}, 64'd0);
    @(negedge clk);
    chk("abort_done2", {63'h0, sched_done}, 64'd0);
    abort = 1'b1;
    send_key(KEY, 1'b1);
    abort = 1'b0;
    expect_run(1'b1);

    // Test 5: asynchronous reset at idx10
    send_key(KEY, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk_key(i, 1'b0);
      @(negedge clk);
    end
    chk_key(10, 1'b0);
    rst = 1'b1;
    #1;
    chk("arst_valid", {63'h0, rk_valid}, 64'd0);
    chk("arst_idx", {60'h0, round_idx}, 64'd0);
    chk("arst_kready", {63'h0, key_ready}, 64'd1);
    chk("arst_last", {63'h0, rk_last}, 64'd0);
    chk("arst_done", {63'h0, sched_done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_key(KEY, 1'b0);
    expect_run(1'b0);

    // Test 6: last byte with even parity
    send_key(64'h133457799BBCDFF0, 1'b0);
`ifdef DES_KS_PARITY_CHECK_EN
    chk("par_err", {63'h0, parity_err}, 64'd1);
    chk("par_valid", {63'h0, rk_valid}, 64'd0);
    chk("par_kready", {63'h0, key_ready}, 64'd1);
    @(negedge clk);
    chk("par_err_clear", {63'h0, parity_err}, 64'd0);
    chk("par_valid2", {63'h0, rk_valid}, 64'd0);
`else
    chk("par_err_tied", {63'h0, parity_err}, 64'd0);
    expect_run(1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
